// File: rtl/pipeline_control_unit.sv
// Pipeline freeze/bubble/flush controller for the 5-stage core.
// It also owns the memory-timeout error state and the stall, flush and memory-wait counters.
module pipeline_control_unit #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_pipeline,
    input  logic             branch_taken,
    input  logic             mem_access,
    input  logic             mem_ready,
    input  logic             halt_id,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             halted,
    output logic             bus_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED, ERROR} state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [31:0]       wait_next;
    logic              active;
    logic              freeze;
    logic              do_branch;
    logic              do_stall;
    logic              do_halt;

    // Request arbitration: freeze > branch > load-use stall > halt
    always_comb begin
        active    = (state == RUN) || (state == MEM_WAIT);
        freeze    = mem_access & ~mem_ready;
        do_branch = active & ~freeze & branch_taken;
        do_stall  = active & ~freeze & ~branch_taken & stall_pipeline;
        do_halt   = active & ~freeze & ~branch_taken & ~stall_pipeline & halt_id;
        wait_next = 32'(wait_cnt) + 32'd1;
    end

    // Stage enable/flush decode; everything held off while reset is asserted
    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_write = 1'b0;
        if (!rst) begin
            case (state)
                RUN, MEM_WAIT: begin
                    if (!freeze) begin
                        pc_write     = ~(do_stall | do_halt);
                        if_id_write  = ~do_stall;
                        if_id_flush  = do_branch | do_halt;
                        id_ex_write  = 1'b1;
                        id_ex_flush  = do_branch | do_stall;
                        ex_mem_write = 1'b1;
                        mem_wb_write = 1'b1;
                    end
                end
                HALTED: begin
                    id_ex_write  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_write = 1'b1;
                    mem_wb_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        halted    = (state == HALTED) || (state == ERROR);
        bus_error = (state == ERROR);
    end

    // State, memory-wait timer and saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            memwait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (freeze) begin
                        wait_cnt <= WAIT_W'(1);
                        state    <= (MEM_TIMEOUT <= 1) ? ERROR : MEM_WAIT;
                    end else if (do_halt) begin
                        state <= HALTED;
                    end
                end
                MEM_WAIT: begin
                    if (freeze) begin
                        wait_cnt <= WAIT_W'(wait_next);
                        if (wait_next >= MEM_TIMEOUT) begin
                            state <= ERROR;
                        end
                    end else begin
                        wait_cnt <= '0;
                        state    <= do_halt ? HALTED : RUN;
                    end
                end
                default: ;
            endcase

            if (do_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (do_branch && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if (active && freeze && (memwait_cnt != '1)) begin
                memwait_cnt <= memwait_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Self-checking bench for pipeline_control_unit: vector table, hand sequences and an expected-control queue.
module tb_pipeline_control_unit;

    logic clk = 1'b0;
    logic rst, stall_pipeline, branch_taken, mem_access, mem_ready, halt_id;

    logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_write;
    logic halted, bus_error;
    logic [31:0] stall_cnt, flush_cnt, memwait_cnt;

    logic t_pc_write, t_if_id_write, t_if_id_flush, t_id_ex_write, t_id_ex_flush;
    logic t_ex_mem_write, t_mem_wb_write, t_halted, t_bus_error;
    logic [3:0] t_stall_cnt, t_flush_cnt, t_memwait_cnt;

    always #5 clk = ~clk;

    pipeline_control_unit dut (
        .clk(clk), .rst(rst), .stall_pipeline(stall_pipeline), .branch_taken(branch_taken),
        .mem_access(mem_access), .mem_ready(mem_ready), .halt_id(halt_id),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write),
        .mem_wb_write(mem_wb_write), .halted(halted), .bus_error(bus_error),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
    );

    // Short timeout and narrow counters for the error and saturation corners
    pipeline_control_unit #(.MEM_TIMEOUT(4), .CNT_W(4)) dut_t (
        .clk(clk), .rst(rst), .stall_pipeline(stall_pipeline), .branch_taken(branch_taken),
        .mem_access(mem_access), .mem_ready(mem_ready), .halt_id(halt_id),
        .pc_write(t_pc_write), .if_id_write(t_if_id_write), .if_id_flush(t_if_id_flush),
        .id_ex_write(t_id_ex_write), .id_ex_flush(t_id_ex_flush), .ex_mem_write(t_ex_mem_write),
        .mem_wb_write(t_mem_wb_write), .halted(t_halted), .bus_error(t_bus_error),
        .stall_cnt(t_stall_cnt), .flush_cnt(t_flush_cnt), .memwait_cnt(t_memwait_cnt)
    );

    // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_write}
    localparam logic [6:0] C_OFF  = 7'b0000000;
    localparam logic [6:0] C_NORM = 7'b1101011;
    localparam logic [6:0] C_BR   = 7'b1111111;
    localparam logic [6:0] C_STL  = 7'b0001111;
    localparam logic [6:0] C_HLT  = 7'b0111011;
    localparam logic [6:0] C_HLTD = 7'b0001111;

    typedef struct {
        logic       rst, stall, br, macc, mrdy, halt;
        logic [6:0] ctl;
        string      name;
    } vec_t;

    typedef struct {
        logic [6:0] ctl;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [6:0] ctl_now();
        return {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_write};
    endfunction

    function automatic logic [6:0] ctl_t_now();
        return {t_pc_write, t_if_id_write, t_if_id_flush, t_id_ex_write, t_id_ex_flush,
                t_ex_mem_write, t_mem_wb_write};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of requests, queue the expected controls, compare mid-cycle, advance past the edge
    task automatic step(input logic r, input logic s, input logic b, input logic ma, input logic mr,
                        input logic h, input logic [6:0] e, input string nm);
        exp_t item;
        rst = r; stall_pipeline = s; branch_taken = b; mem_access = ma; mem_ready = mr; halt_id = h;
        exp_q.push_back('{ctl: e, name: nm});
        @(negedge clk);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            item = exp_q.pop_front();
            check(item.name, 32'(ctl_now()), 32'(item.ctl));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [6:0] e, input string nm);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e, nm);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_OFF, "reset_ctl");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, "v_idle"};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_STL,  "v_stall"};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_BR,   "v_branch_stall"};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, C_BR,   "v_branch_halt"};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, C_OFF,  "v_freeze_all"};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_NORM, "v_mem_ready"};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, C_STL,  "v_ready_stall"};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_NORM, "v_ready_no_access"};

        // Reset with every request asserted
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, C_OFF, "reset_all_req_0");
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, C_OFF, "reset_all_req_1");
        check("reset_stall_cnt", stall_cnt, 32'd0);
        check("reset_flush_cnt", flush_cnt, 32'd0);
        check("reset_memwait_cnt", memwait_cnt, 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_bus_error", 32'(bus_error), 32'd0);

        foreach (vecs[i])
            step(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].macc, vecs[i].mrdy, vecs[i].halt,
                 vecs[i].ctl, vecs[i].name);
        check("table_stall_cnt", stall_cnt, 32'd2);
        check("table_flush_cnt", flush_cnt, 32'd2);
        check("table_memwait_cnt", memwait_cnt, 32'd1);
        check("table_halted", 32'(halted), 32'd0);

        // Single load-use bubble
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_STL, "loaduse_ctl");
        check("loaduse_stall_cnt", stall_cnt, 32'd1);
        idle(C_NORM, "loaduse_after");

        // Branch wins over same-cycle load-use stall
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_BR, "br_stall_ctl");
        check("br_stall_flush_cnt", flush_cnt, 32'd1);
        check("br_stall_stall_cnt", stall_cnt, 32'd0);

        // Five frozen cycles then memory ready
        do_reset();
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_OFF, "memwait_frozen");
        check("memwait_cnt_5", memwait_cnt, 32'd5);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_NORM, "memwait_ready");
        check("memwait_cnt_final", memwait_cnt, 32'd5);
        check("memwait_no_error", 32'(bus_error), 32'd0);
        idle(C_NORM, "memwait_back_to_run");

        // Memory never ready on the short-timeout instance
        do_reset();
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_OFF, "timeout_frozen");
        check("timeout_not_yet", 32'(t_bus_error), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_OFF, "timeout_frozen_last");
        check("timeout_bus_error", 32'(t_bus_error), 32'd1);
        check("timeout_halted", 32'(t_halted), 32'd1);
        check("timeout_long_dut_ok", 32'(bus_error), 32'd0);
        rst = 1'b0; stall_pipeline = 1'b0; branch_taken = 1'b0; mem_access = 1'b0; halt_id = 1'b0;
        #1;
        check("timeout_writes_off", 32'(ctl_t_now()), 32'(C_OFF));
        idle(C_NORM, "timeout_long_dut_resumes");
        check("timeout_sticky", 32'(t_bus_error), 32'd1);
        do_reset();
        check("timeout_cleared", 32'(t_bus_error), 32'd0);

        // Halt then drain for 20 cycles regardless of requests
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_HLT, "halt_decode");
        check("halt_halted", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                 1'($urandom_range(1)), 1'($urandom_range(1)), C_HLTD, "halted_hold");
        check("halt_still", 32'(halted), 32'd1);
        check("halt_not_error", 32'(bus_error), 32'd0);
        do_reset();
        check("halt_reset", 32'(halted), 32'd0);
        idle(C_NORM, "halt_reset_run");

        // Counter saturation on the 4-bit instance
        do_reset();
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_STL, "sat_stall");
        check("sat_wide", stall_cnt, 32'd20);
        check("sat_narrow", 32'(t_stall_cnt), 32'd15);

        // Reset in the middle of a freeze leaves nothing pending
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_OFF, "midfreeze_frozen");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_OFF, "midfreeze_frozen");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_OFF, "midfreeze_reset");
        check("midfreeze_memwait_cnt", memwait_cnt, 32'd0);
        idle(C_NORM, "midfreeze_run");
        check("midfreeze_no_error", 32'(t_bus_error), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
